// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the PISO serial transmitter: state encodings and default word width.
// The default width is the same one the SIPO receiver uses.
package piso_shift_tx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Bit-counter width for a given word width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Bit-position counter for the PISO transmitter. It counts up from 0, stops at WIDTH-1 without
// wrapping, and raises term while the count sits at WIDTH-1.
module piso_shift_tx_bit_counter
  import piso_shift_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // Clear wins over enable; the count saturates at the last bit position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: it accepts a word through valid/ready and sends one bit per
// enabled clock. Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             we,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             term;
  logic             accept;
  logic             last_bit;
  logic             cnt_en;
  logic             cnt_clr;
  logic             first_bit;
  logic             next_bit;

  // The bit that goes on the line is always taken from the leading end of shreg.
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

`ifdef PISO_TX_PARITY_EN
  logic parity;
  assign last_bit = (state == ST_PARITY) && we;
`else
  assign last_bit = (state == ST_SHIFT) && term && we;
`endif

  // A new word may arrive in the same edge that consumes the final bit of the current frame.
  assign load_ready = (state == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign cnt_en     = (state == ST_SHIFT) && we;
  assign cnt_clr    = accept || last_bit;

  piso_shift_tx_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .term(term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done <= last_bit;
      if (accept) begin
        state     <= ST_SHIFT;
        shreg     <= load_data;
        out       <= first_bit;
        out_valid <= 1'b1;
        busy      <= 1'b1;
`ifdef PISO_TX_PARITY_EN
        parity    <= ^load_data;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
          ST_SHIFT: begin
            if (we) begin
              if (term) begin
`ifdef PISO_TX_PARITY_EN
                state <= ST_PARITY;
                out   <= parity;
`else
                state     <= ST_IDLE;
                out       <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
`endif
              end else begin
                shreg <= shifted;
                out   <= next_bit;
              end
            end
          end
`ifdef PISO_TX_PARITY_EN
          ST_PARITY: begin
            if (we) begin
              state     <= ST_IDLE;
              out       <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
`endif
          default: begin
            state     <= ST_IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed scenarios plus a randomized run against a
// bit-index reference model. It honours PISO_TX_PARITY_EN.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         we = 1'b0;
  logic         load_ready;
  logic         out;
  logic         out_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(
    .WIDTH    (W),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .we        (we),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  // Frame bit i of word w, MSB first; index W is the even-parity bit.
  function automatic logic bit_of(input logic [W-1:0] w, input int i);
    if (i >= W) return ^w;
    return w[W-1-i];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out=%b out_valid=%b busy=%b done=%b, expected 0 0 0 0",
               out, out_valid, busy, done);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: load_ready=%b expected 1", load_ready);
    end
  endtask

  task automatic test_single(input logic [W-1:0] word, input string tag);
    do_reset();
    load_data = word;
    load_valid = 1'b1;
    we = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_data = '0;
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid bit%0d: out_valid=%b busy=%b expected 1 1", tag, i, out_valid, busy);
      end
      checks++;
      if (out !== bit_of(word, i)) begin
        errors++;
        $display("FAIL %s_bit%0d: out=%b expected %b", tag, i, out, bit_of(word, i));
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_done bit%0d: done=%b expected 0", tag, i, done);
      end
      checks++;
      if (load_ready !== logic'(i == FRAME - 1)) begin
        errors++;
        $display("FAIL %s_ready bit%0d: load_ready=%b expected %b", tag, i, load_ready,
                 logic'(i == FRAME - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: done=%b out_valid=%b busy=%b out=%b expected 1 0 0 0",
               tag, done, out_valid, busy, out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b expected 0", tag, done);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int stalls = 0;
    int held = 0;
    do_reset();
    load_data = 8'hB2;
    load_valid = 1'b1;
    we = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < FRAME + 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== bit_of(8'hB2, k) || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: out=%b out_valid=%b done=%b expected %b 1 0",
                 c, out, out_valid, done, bit_of(8'hB2, k));
      end
      if (k == 2) held++;
      if (k == 2 && stalls < 3) begin
        we = 1'b0;
        stalls++;
      end else begin
        we = 1'b1;
      end
      @(negedge clk);
      if (we) k++;
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || held != 4) begin
      errors++;
      $display("FAIL stall_end: done=%b out_valid=%b held=%0d expected 1 0 4", done, out_valid, held);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    logic [W-1:0] w;
    do_reset();
    load_data = 8'hB2;
    load_valid = 1'b1;
    we = 1'b1;
    @(negedge clk);
    load_data = 8'h5C;
    for (int j = 0; j < 2 * FRAME; j++) begin
      w = (j < FRAME) ? 8'hB2 : 8'h5C;
      checks++;
      if (out_valid !== 1'b1 || out !== bit_of(w, j % FRAME)) begin
        errors++;
        $display("FAIL b2b_bit%0d: out=%b out_valid=%b expected %b 1", j, out, out_valid,
                 bit_of(w, j % FRAME));
      end
      checks++;
      if (done !== logic'(j == FRAME)) begin
        errors++;
        $display("FAIL b2b_done%0d: done=%b expected %b", j, done, logic'(j == FRAME));
      end
      if (done === 1'b1) dones++;
      if (j == FRAME) load_valid = 1'b0;
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || dones != 2) begin
      errors++;
      $display("FAIL b2b_end: done=%b out_valid=%b dones=%0d expected 1 0 2", done, out_valid, dones);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_data = 8'hFF;
    load_valid = 1'b1;
    we = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_now: out=%b out_valid=%b busy=%b done=%b expected 0 0 0 0",
               out, out_valid, busy, done);
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: load_ready=%b expected 1", load_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after%0d: done=%b out_valid=%b expected 0 0", c, done, out_valid);
      end
    end
  endtask

  task automatic test_ignore();
    do_reset();
    load_data = 8'hA5;
    load_valid = 1'b1;
    we = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      load_valid = (i >= 2 && i <= 4);
      load_data = 8'h00;
      #1;
      checks++;
      if (load_ready !== logic'(i == FRAME - 1)) begin
        errors++;
        $display("FAIL ignore_ready%0d: load_ready=%b expected %b", i, load_ready,
                 logic'(i == FRAME - 1));
      end
      checks++;
      if (out !== bit_of(8'hA5, i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ignore_bit%0d: out=%b out_valid=%b expected %b 1", i, out, out_valid,
                 bit_of(8'hA5, i));
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done=%b expected 1", done);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_random(input int n);
    bit active = 1'b0;
    bit exp_done = 1'b0;
    bit exp_ready;
    bit last;
    logic [W-1:0] cur = '0;
    int k = 0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      checks++;
      if (out_valid !== active || busy !== active) begin
        errors++;
        $display("FAIL rand_valid%0d: out_valid=%b busy=%b expected %b", c, out_valid, busy, active);
      end
      checks++;
      if (out !== (active ? bit_of(cur, k) : 1'b0)) begin
        errors++;
        $display("FAIL rand_out%0d: out=%b expected %b", c, out, active ? bit_of(cur, k) : 1'b0);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL rand_done%0d: done=%b expected %b", c, done, exp_done);
      end
      we = ($urandom_range(0, 3) != 0);
      load_valid = 1'($urandom_range(0, 1));
      load_data = W'($urandom);
      #1;
      exp_ready = !active || (k == FRAME - 1 && we);
      checks++;
      if (load_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready%0d: load_ready=%b expected %b", c, load_ready, exp_ready);
      end
      last = active && we && (k == FRAME - 1);
      exp_done = last;
      if (load_valid && exp_ready) begin
        active = 1'b1;
        cur = load_data;
        k = 0;
      end else if (active && we) begin
        if (last) active = 1'b0;
        else k++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    we = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single(8'hB2, "basic");
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
`ifdef PISO_TX_PARITY_EN
    test_single(8'h07, "parity07");
`endif
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
